dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (DMEM) between the ARM core load/store path (CPU port) and an

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter_if : CPU / EXT request ports and DMEM side of dmem_arbiter    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter : round-robin, burst-limited sharing of single-port DMEM      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  dmem_arbiter_if.slave   bus
);

  localparam int c_CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_BURST);
  localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_EXT = 2'd2
  } owner_t;

  owner_t             r_owner, w_owner_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               w_gnt_cpu, w_gnt_ext;
  logic               r_cpu_rvalid, r_ext_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant is suppressed while reset is high so no access slips into DMEM
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_ext = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && !bus.ext_req) begin
        w_gnt_cpu = 1'b1;
      end else if (!bus.cpu_req && bus.ext_req) begin
        w_gnt_ext = 1'b1;
      end else if (bus.cpu_req && bus.ext_req) begin
        case (r_owner)
          OWN_CPU: begin
            if (r_cnt < c_MAX) w_gnt_cpu = 1'b1;
            else               w_gnt_ext = 1'b1;
          end
          OWN_EXT: begin
            if (r_cnt < c_MAX) w_gnt_ext = 1'b1;
            else               w_gnt_cpu = 1'b1;
          end
          default: w_gnt_cpu = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    w_owner_nxt = IDLE;
    w_cnt_nxt   = '0;
    if (w_gnt_cpu) begin
      w_owner_nxt = OWN_CPU;
      if (r_owner == OWN_CPU) w_cnt_nxt = (r_cnt == c_MAX) ? c_MAX : r_cnt + c_ONE;
      else                    w_cnt_nxt = c_ONE;
    end else if (w_gnt_ext) begin
      w_owner_nxt = OWN_EXT;
      if (r_owner == OWN_EXT) w_cnt_nxt = (r_cnt == c_MAX) ? c_MAX : r_cnt + c_ONE;
      else                    w_cnt_nxt = c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_gnt_cpu & ~bus.cpu_we;
      r_ext_rvalid <= w_gnt_ext & ~bus.ext_we;
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_gnt_cpu) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (w_gnt_ext) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  assign bus.cpu_gnt    = w_gnt_cpu;
  assign bus.ext_gnt    = w_gnt_ext;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ext_rvalid = r_ext_rvalid;
  assign bus.cpu_rdata  = r_cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata  = r_ext_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed scoreboard bench for dmem_arbiter               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int c_AW = 32;
  localparam int c_DW = 32;

  typedef struct packed {
    logic            port;   // 0 = CPU, 1 = EXT
    logic            we;
    logic [c_AW-1:0] addr;
    logic [c_DW-1:0] wdata;
  } gexp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  gexp_t           gq[$];
  logic [c_DW-1:0] cq[$];
  logic [c_DW-1:0] eq[$];

  logic [c_DW-1:0] mem [0:1023];
  logic [c_DW-1:0] r_mem_rdata;

  dmem_arbiter_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) ifc ();

  dmem_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM model: 1-cycle synchronous read, read-before-write
  always @(posedge clk) begin
    if (ifc.mem_we) mem[ifc.mem_addr[9:0]] <= ifc.mem_wdata;
    r_mem_rdata <= mem[ifc.mem_addr[9:0]];
  end
  assign ifc.mem_rdata = r_mem_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [c_AW-1:0] ca, input logic [c_DW-1:0] cd,
                       input logic er, input logic ew, input logic [c_AW-1:0] ea, input logic [c_DW-1:0] ed);
    ifc.cpu_req = cr; ifc.cpu_we = cw; ifc.cpu_addr = ca; ifc.cpu_wdata = cd;
    ifc.ext_req = er; ifc.ext_we = ew; ifc.ext_addr = ea; ifc.ext_wdata = ed;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input logic port, input logic we, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
    gexp_t g;
    g.port = port; g.we = we; g.addr = a; g.wdata = d;
    gq.push_back(g);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or read data
  initial begin
    gexp_t g;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ifc.cpu_gnt && ifc.ext_gnt) check("both_gnt", 64'd1, 64'd0);
        if (ifc.cpu_gnt || ifc.ext_gnt) begin
          if (gq.size() == 0) begin
            check("unexpected_gnt", {63'd0, ifc.ext_gnt}, 64'hdead);
          end else begin
            g = gq.pop_front();
            check("gnt_port", {62'd0, ifc.ext_gnt, ifc.cpu_gnt}, {62'd0, g.port, ~g.port});
            check("gnt_access", {ifc.mem_we, ifc.mem_addr[30:0], ifc.mem_wdata},
                                {g.we, g.addr[30:0], g.wdata});
          end
        end else begin
          check("idle_bus", {ifc.mem_we, ifc.mem_addr[30:0], ifc.mem_wdata}, 64'd0);
        end
        if (ifc.cpu_rvalid) begin
          if (cq.size() == 0) check("unexpected_cpu_rvalid", {32'd0, ifc.cpu_rdata}, 64'hdead);
          else                check("cpu_rdata", {32'd0, ifc.cpu_rdata}, {32'd0, cq.pop_front()});
        end
        if (ifc.ext_rvalid) begin
          if (eq.size() == 0) check("unexpected_ext_rvalid", {32'd0, ifc.ext_rdata}, 64'hdead);
          else                check("ext_rdata", {32'd0, ifc.ext_rdata}, {32'd0, eq.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1;

    // Reset held with both requests high
    drive(1, 1, 32'd100, 32'd1, 1, 1, 32'd200, 32'd2);
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", {62'd0, ifc.cpu_gnt, ifc.ext_gnt}, 64'd0);
      check("rst_we_rvalid", {61'd0, ifc.mem_we, ifc.cpu_rvalid, ifc.ext_rvalid}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    tick();

    // CPU-only write then read
    drive(1, 1, 32'd100, 32'd7, 0, 0, 0, 0);
    exp_gnt(0, 1, 32'd100, 32'd7);
    tick();
    drive(1, 0, 32'd100, 32'd0, 0, 0, 0, 0);
    exp_gnt(0, 0, 32'd100, 32'd0);
    cq.push_back(32'd7);
    tick();
    idle();
    tick();

    // Both held from IDLE: CPU x4, EXT x4, CPU x4
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 32'd100, 32'd0, 1, 1, 32'd200, 32'h55);
      if (i < 4 || i >= 8) begin
        exp_gnt(0, 0, 32'd100, 32'd0);
        cq.push_back(32'd7);
      end else begin
        exp_gnt(1, 1, 32'd200, 32'h55);
      end
      tick();
    end
    idle();
    tick();

    // EXT alone two cycles, CPU joins: EXT twice more, then CPU
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'd200, 32'd0);
      exp_gnt(1, 0, 32'd200, 32'd0);
      eq.push_back(32'h55);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'd300, 32'hAA, 1, 0, 32'd200, 32'd0);
      if (i < 2) begin
        exp_gnt(1, 0, 32'd200, 32'd0);
        eq.push_back(32'h55);
      end else begin
        exp_gnt(0, 1, 32'd300, 32'hAA);
      end
      tick();
    end
    idle();
    tick();

    // EXT read then CPU write same address: EXT sees old data
    drive(0, 0, 0, 0, 1, 0, 32'd100, 32'd0);
    exp_gnt(1, 0, 32'd100, 32'd0);
    eq.push_back(32'd7);
    tick();
    drive(1, 1, 32'd100, 32'd9, 0, 0, 0, 0);
    exp_gnt(0, 1, 32'd100, 32'd9);
    tick();
    idle();
    tick();
    drive(1, 0, 32'd100, 32'd0, 0, 0, 0, 0);
    exp_gnt(0, 0, 32'd100, 32'd0);
    cq.push_back(32'd9);
    tick();
    idle();
    tick();

    // Reset mid CPU write burst
    drive(1, 1, 32'd40, 32'd1, 0, 0, 0, 0);
    exp_gnt(0, 1, 32'd40, 32'd1);
    tick();
    drive(1, 1, 32'd44, 32'd2, 0, 0, 0, 0);
    exp_gnt(0, 1, 32'd44, 32'd2);
    tick();
    reset = 1'b1;
    drive(1, 1, 32'd48, 32'd3, 1, 0, 32'd44, 32'd0);
    @(negedge clk);
    check("midrst_gnt", {62'd0, ifc.cpu_gnt, ifc.ext_gnt}, 64'd0);
    check("midrst_we", {63'd0, ifc.mem_we}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_rvalid", {62'd0, ifc.cpu_rvalid, ifc.ext_rvalid}, 64'd0);
    drive(1, 0, 32'd48, 32'd0, 1, 0, 32'd44, 32'd0);
    exp_gnt(0, 0, 32'd48, 32'd0);
    cq.push_back(32'd0);
    tick();
    idle();
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'd44, 32'd0);
    exp_gnt(1, 0, 32'd44, 32'd0);
    eq.push_back(32'd2);
    tick();
    idle();
    repeat (3) tick();

    check("gnt_queue_drained", 64'(gq.size()), 64'd0);
    check("cpu_queue_drained", 64'(cq.size()), 64'd0);
    check("ext_queue_drained", 64'(eq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
